// File: rtl/sdram_arb_multi.sv
// sdram_arb_multi: N-port arbiter in front of a single sdram_core_32bit request
// channel.
//
// Arbitration is hybrid. Ports 0..PRIO_PORTS-1 are fixed priority, and the lowest
// index wins. The remaining ports share a round-robin pointer. A grant is
// registered in IDLE and presented to the core from BUSY, so each request takes
// at least 2 cycles. Outstanding reads are tracked in an in-order tag FIFO, which
// routes every core read ack back to the port that issued the read.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   p_rd / p_wr         per-port read request / write byte enables (wr wins)
//   p_addr / p_wdata    per-port address / write data (slice i = port i)
//   p_accept            per-port request taken
//   p_ack / p_rdata     per-port read data valid / read data (broadcast)
//   c_rd/c_wr/c_addr/c_wdata, c_accept   core request channel
//   c_ack / c_rdata     core read return, in issue order
//   err_orphan          sticky: c_ack arrived with no outstanding read
//
// Optional: define SDRAM_ARB_STATS_EN to add per-port worst-case latency
// counters (lat_max, 16 bits per port) and a synchronous clear input (stats_clr).

`ifdef SDRAM_ARB_STATS_EN
// Per-port worst-case latency tracker. It measures one request at a time. The
// measurement starts when a new request appears and ends at accept for a write,
// or at the matching p_ack for a read. Reads already outstanding from this port
// at accept time are skipped, because their acks arrive first.
module sdram_arb_lat #(
    parameter int CW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        req,
    input  logic        accept,
    input  logic        accept_rd,
    input  logic        ack,
    output logic [15:0] lat_max
);
    logic          pend, meas, phase, start, active, done;
    logic [15:0]   run, cur;
    logic [CW-1:0] outst, skip;

    // pend marks a request that is already visible but not yet accepted, so a
    // request held across several cycles starts only one measurement.
    assign start  = req & ~pend & ~meas;
    assign active = start | meas;
    assign cur    = !meas ? 16'd1 : (run == 16'hFFFF) ? run : run + 16'd1;
    assign done   = active & ((~phase & accept & ~accept_rd) |
                              (phase & ack & (skip == '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            meas    <= 1'b0;
            phase   <= 1'b0;
            run     <= '0;
            outst   <= '0;
            skip    <= '0;
            lat_max <= '0;
        end else begin
            pend  <= accept ? 1'b0 : (pend | req);
            outst <= outst + CW'(accept_rd) - CW'(ack);
            if (active) run <= cur;
            if (active & ~phase & accept_rd) begin
                phase <= 1'b1;
                skip  <= ack ? outst - CW'(1) : outst;
            end else if (phase & ack & (skip != '0)) begin
                skip <= skip - CW'(1);
            end
            if (done) phase <= 1'b0;
            meas <= active & ~done;
            if (clr)
                lat_max <= '0;
            else if (done && cur > lat_max)
                lat_max <= cur;
        end
    end
endmodule
`endif

module sdram_arb_multi #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MASK_W     = DATA_W/8,
    parameter int PRIO_PORTS = 1,
    parameter int RD_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          p_rd,
    input  logic [NUM_PORTS*MASK_W-1:0]   p_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_wdata,
    output logic [NUM_PORTS-1:0]          p_accept,
    output logic [NUM_PORTS-1:0]          p_ack,
    output logic [DATA_W-1:0]             p_rdata,
    output logic                          c_rd,
    output logic [MASK_W-1:0]             c_wr,
    output logic [ADDR_W-1:0]             c_addr,
    output logic [DATA_W-1:0]             c_wdata,
    input  logic                          c_accept,
    input  logic                          c_ack,
    input  logic [DATA_W-1:0]             c_rdata,
`ifdef SDRAM_ARB_STATS_EN
    input  logic                          stats_clr,
    output logic [NUM_PORTS*16-1:0]       lat_max,
`endif
    output logic                          err_orphan
);
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int CW = $clog2(RD_DEPTH + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, nxt;
    logic [GW-1:0] g, rr_ptr, sel_idx, prio_idx, rr_idx;
    logic          sel_vld, prio_hit, rr_hit, act, acc, push, pop, g_is_rr;
    int            idx;

    logic [NUM_PORTS-1:0][MASK_W-1:0] wr_v;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_v;
    logic [NUM_PORTS-1:0]             is_wr, req, elig;

    logic [GW-1:0] tags [RD_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;
    logic          fifo_full, fifo_empty;

    assign wr_v    = p_wr;
    assign addr_v  = p_addr;
    assign wdata_v = p_wdata;

    // Request decode. A write wins over a simultaneous read. A read is held
    // off while the tag FIFO has no room for its tag.
    genvar i;
    generate
        for (i = 0; i < NUM_PORTS; i++) begin : g_req
            assign is_wr[i] = |wr_v[i];
            assign req[i]   = p_rd[i] | is_wr[i];
            assign elig[i]  = is_wr[i] | (p_rd[i] & ~fifo_full);
        end
    endgenerate

    // Selection: the lowest eligible priority port wins. Otherwise the first
    // eligible round-robin port after rr_ptr is chosen, with wrap. Each loop
    // runs from high to low, so the last assignment is the winner.
    always_comb begin
        prio_hit = 1'b0;
        prio_idx = '0;
        rr_hit   = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        for (int p = PRIO_PORTS - 1; p >= 0; p--) begin
            if (elig[p]) begin
                prio_hit = 1'b1;
                prio_idx = GW'(p);
            end
        end
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_PORTS;
            if (idx >= PRIO_PORTS && elig[idx]) begin
                rr_hit = 1'b1;
                rr_idx = GW'(idx);
            end
        end
        sel_vld = prio_hit | rr_hit;
        sel_idx = prio_hit ? prio_idx : rr_idx;
    end

    // The grant is presented only while the granted client still requests.
    // If the request is dropped early, the core outputs go quiet and the FSM
    // falls back to IDLE.
    assign act     = (state == BUSY) & req[g];
    assign acc     = act & c_accept;
    assign push    = acc & ~is_wr[g];
    assign g_is_rr = int'(g) >= PRIO_PORTS;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (sel_vld) nxt = BUSY;
            BUSY:    if (!req[g] || c_accept) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            g      <= '0;
            rr_ptr <= GW'(NUM_PORTS - 1);
        end else begin
            state <= nxt;
            if (state == IDLE && sel_vld) g <= sel_idx;
            if (acc && g_is_rr) rr_ptr <= g;
        end
    end

    assign c_rd     = act & p_rd[g] & ~is_wr[g];
    assign c_wr     = act ? wr_v[g]    : '0;
    assign c_addr   = act ? addr_v[g]  : '0;
    assign c_wdata  = act ? wdata_v[g] : '0;
    assign p_accept = acc ? (NUM_PORTS'(1) << g) : '0;

    // In-order tag FIFO of issuing port indices for outstanding reads.
    // Push and pop can happen in the same cycle. The tag being popped is
    // always an older entry, so the count simply holds.
    assign fifo_full  = (cnt == CW'(RD_DEPTH));
    assign fifo_empty = (cnt == '0);
    assign pop        = c_ack & ~fifo_empty;
    assign p_ack      = pop ? (NUM_PORTS'(1) << tags[rptr]) : '0;
    assign p_rdata    = pop ? c_rdata : '0;

    always_ff @(posedge clk) begin
        if (push) tags[wptr] <= g;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) wptr <= (wptr == PW'(RD_DEPTH - 1)) ? '0 : wptr + PW'(1);
            if (pop)  rptr <= (rptr == PW'(RD_DEPTH - 1)) ? '0 : rptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
            if (c_ack && fifo_empty) err_orphan <= 1'b1;
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    generate
        for (i = 0; i < NUM_PORTS; i++) begin : g_lat
            sdram_arb_lat #(.CW(CW)) u_lat (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (stats_clr),
                .req       (req[i]),
                .accept    (p_accept[i]),
                .accept_rd (p_accept[i] & ~is_wr[i]),
                .ack       (p_ack[i]),
                .lat_max   (lat_max[i*16 +: 16])
            );
        end
    endgenerate
`endif

endmodule

// File: tb/tb_sdram_arb_multi.sv
// Directed testbench for sdram_arb_multi with the default configuration:
// 4 ports, 1 priority port, and 4 outstanding reads.
module tb_sdram_arb_multi;
    localparam int NP = 4;
    localparam int MW = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     p_rd;
    logic [NP*MW-1:0]  p_wr;
    logic [NP*AW-1:0]  p_addr;
    logic [NP*DW-1:0]  p_wdata;
    logic [NP-1:0]     p_accept, p_ack;
    logic [DW-1:0]     p_rdata, c_wdata, c_rdata;
    logic              c_rd, c_accept, c_ack, err_orphan;
    logic [MW-1:0]     c_wr;
    logic [AW-1:0]     c_addr;
`ifdef SDRAM_ARB_STATS_EN
    logic              stats_clr;
    logic [NP*16-1:0]  lat_max;
`endif

    int checks = 0;
    int errors = 0;

    // Values captured by issue() in the cycle the port is accepted.
    int          cyc;
    logic        crd;
    logic [3:0]  cwr;
    logic [31:0] caddr, cwd;

    sdram_arb_multi #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
        .PRIO_PORTS(1), .RD_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_accept(p_accept), .p_ack(p_ack), .p_rdata(p_rdata),
        .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_accept(c_accept), .c_ack(c_ack), .c_rdata(c_rdata),
`ifdef SDRAM_ARB_STATS_EN
        .stats_clr(stats_clr), .lat_max(lat_max),
`endif
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p_rd = '0; p_wr = '0; p_addr = '0; p_wdata = '0;
        c_accept = 1'b1; c_ack = 1'b0; c_rdata = '0;
`ifdef SDRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic int oh_idx(input logic [NP-1:0] v);
        int r = -1;
        for (int k = 0; k < NP; k++) if (v[k]) r = k;
        return r;
    endfunction

    // Presents one request on port p and waits (bounded) for p_accept[p].
    // It returns the number of edges before the accept (-1 on timeout) and the
    // core-side view in the accept cycle. The request is dropped once the
    // accept edge has passed.
    task automatic issue(input int p, input logic rd, input logic [3:0] wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int ncyc, output logic o_rd, output logic [3:0] o_wr,
                         output logic [31:0] o_addr, output logic [31:0] o_wd);
        p_rd[p] = rd;
        p_wr[p*MW +: MW] = wr;
        p_addr[p*AW +: AW] = addr;
        p_wdata[p*DW +: DW] = wdata;
        ncyc = -1; o_rd = 1'b0; o_wr = '0; o_addr = '0; o_wd = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (p_accept[p]) begin
                ncyc = c; o_rd = c_rd; o_wr = c_wr; o_addr = c_addr; o_wd = c_wdata;
                break;
            end
            tick();
        end
        if (ncyc >= 0) tick();
        p_rd[p] = 1'b0;
        p_wr[p*MW +: MW] = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        checks++; if (p_accept !== 4'b0) begin errors++; $display("FAIL reset_accept: got %b expected 0000", p_accept); end
        checks++; if (p_ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", p_ack); end
        checks++; if (c_rd !== 1'b0 || c_wr !== 4'h0) begin errors++; $display("FAIL reset_core: got rd=%b wr=%h expected 0/0", c_rd, c_wr); end
        checks++; if (c_addr !== 32'h0 || p_rdata !== 32'h0) begin errors++; $display("FAIL reset_data: got addr=%h rdata=%h expected 0", c_addr, p_rdata); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan: got %b expected 0", err_orphan); end
`ifdef SDRAM_ARB_STATS_EN
        checks++; if (lat_max !== '0) begin errors++; $display("FAIL reset_lat: got %h expected 0", lat_max); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        int n;
        do_reset();
        issue(2, 1'b0, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, cyc, crd, cwr, caddr, cwd);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL wr_latency: got %0d expected 1", cyc); end
        checks++; if (crd !== 1'b0 || cwr !== 4'hF) begin errors++; $display("FAIL wr_cmd: got rd=%b wr=%h expected 0/f", crd, cwr); end
        checks++; if (caddr !== 32'h100 || cwd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_payload: got %h/%h expected 00000100/deadbeef", caddr, cwd); end
        n = 0;
        repeat (4) begin if (p_accept !== 4'b0) n++; tick(); end
        checks++; if (n !== 0) begin errors++; $display("FAIL wr_single_accept: got %0d extra expected 0", n); end
        issue(2, 1'b1, 4'h0, 32'h0000_0100, 32'h0, cyc, crd, cwr, caddr, cwd);
        checks++; if (cyc !== 1 || crd !== 1'b1 || cwr !== 4'h0) begin errors++; $display("FAIL rd_cmd: got cyc=%0d rd=%b wr=%h expected 1/1/0", cyc, crd, cwr); end
        checks++; if (caddr !== 32'h100) begin errors++; $display("FAIL rd_addr: got %h expected 00000100", caddr); end
        c_ack = 1'b1; c_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (p_ack !== 4'b0100 || p_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_ack: got %b/%h expected 0100/deadbeef", p_ack, p_rdata); end
        tick(); c_ack = 1'b0; #1;
        checks++; if (p_ack !== 4'b0 || err_orphan !== 1'b0) begin errors++; $display("FAIL rd_ack_clear: got %b orphan=%b expected 0000/0", p_ack, err_orphan); end
    endtask

    task automatic test_fixed_priority();
        int got[9];
        int exp_seq[9] = '{0, 0, 0, 1, 2, 3, 1, 2, 3};
        int n = 0;
        do_reset();
        for (int p = 0; p < NP; p++) p_addr[p*AW +: AW] = 32'(p * 16);
        p_wr = 16'hFFFF;
        for (int c = 0; c < 60 && n < 9; c++) begin
            #1;
            if (p_accept !== 4'b0) begin
                got[n] = oh_idx(p_accept);
                checks++; if (c_addr !== 32'(got[n] * 16)) begin errors++; $display("FAIL prio_addr: got %h expected %h", c_addr, got[n] * 16); end
                n++;
            end
            tick();
            if (n == 3) p_wr[3:0] = 4'h0;
        end
        p_wr = '0;
        checks++; if (n !== 9) begin errors++; $display("FAIL prio_count: got %0d accepts expected 9", n); end
        for (int k = 0; k < n; k++) begin
            checks++; if (got[k] !== exp_seq[k]) begin errors++; $display("FAIL prio_order[%0d]: got port %0d expected %0d", k, got[k], exp_seq[k]); end
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[6] = '{3, 1, 2, 3, 1, 2};
        int cnt[4] = '{0, 0, 0, 0};
        int n = 0, mx, mn, pg;
        do_reset();
        issue(2, 1'b0, 4'hF, 32'h200, 32'h1, cyc, crd, cwr, caddr, cwd);
        p_wr = 16'hFFF0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            #1;
            if (p_accept !== 4'b0) begin
                pg = oh_idx(p_accept);
                checks++; if (pg !== exp_seq[n]) begin errors++; $display("FAIL rr_order[%0d]: got port %0d expected %0d", n, pg, exp_seq[n]); end
                if (pg >= 0) cnt[pg]++;
                mx = cnt[1]; mn = cnt[1];
                for (int k = 2; k < 4; k++) begin
                    if (cnt[k] > mx) mx = cnt[k];
                    if (cnt[k] < mn) mn = cnt[k];
                end
                checks++; if (mx - mn > 1) begin errors++; $display("FAIL rr_fair: got spread %0d expected <=1", mx - mn); end
                n++;
            end
            tick();
        end
        p_wr = '0;
        checks++; if (n !== 6) begin errors++; $display("FAIL rr_count: got %0d expected 6", n); end
    endtask

    task automatic test_violation();
        do_reset();
        c_accept = 1'b0;
        p_rd[1] = 1'b1; p_wr[7:4] = 4'h3; p_addr[63:32] = 32'h40;
        tick();
        checks++; if (c_rd !== 1'b0 || c_wr !== 4'h3 || c_addr !== 32'h40) begin errors++; $display("FAIL wr_wins: got rd=%b wr=%h addr=%h expected 0/3/40", c_rd, c_wr, c_addr); end
        p_rd = '0; p_wr = '0; #1;
        checks++; if (c_rd !== 1'b0 || c_wr !== 4'h0 || c_addr !== 32'h0 || p_accept !== 4'b0) begin errors++; $display("FAIL drop_quiet: got rd=%b wr=%h addr=%h acc=%b expected all 0", c_rd, c_wr, c_addr, p_accept); end
        tick();
        c_accept = 1'b1;
        issue(1, 1'b1, 4'h0, 32'h44, 32'h0, cyc, crd, cwr, caddr, cwd);
        checks++; if (cyc !== 1 || crd !== 1'b1) begin errors++; $display("FAIL drop_idle: got cyc=%0d rd=%b expected 1/1", cyc, crd); end
        c_ack = 1'b1; #1;
        checks++; if (p_ack !== 4'b0010) begin errors++; $display("FAIL drop_ack: got %b expected 0010", p_ack); end
        tick(); c_ack = 1'b0;
    endtask

    task automatic test_fifo_full();
        int n = 0, bad = 0, extra = 0, bad2 = 0;
        bit full_seen = 0, got3 = 0, got1 = 0;
        do_reset();
        p_rd[1] = 1'b1; p_addr[63:32] = 32'h80;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (full_seen && c_rd) bad++;
            if (p_accept[1]) n++;
            tick();
            if (n == 4) full_seen = 1;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL full_accepts: got %0d expected 4", n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_stall: got %0d c_rd cycles expected 0", bad); end
        p_wr[15:12] = 4'hF;
        for (int c = 0; c < 6 && !got3; c++) begin
            #1;
            if (p_accept[1]) extra++;
            if (p_accept[3]) got3 = 1;
            tick();
        end
        p_wr = '0;
        checks++; if (!got3 || extra !== 0) begin errors++; $display("FAIL full_write: got wr_acc=%0d rd_acc=%0d expected 1/0", got3, extra); end
        c_ack = 1'b1; c_rdata = 32'h11; #1;
        checks++; if (p_ack !== 4'b0010 || p_rdata !== 32'h11) begin errors++; $display("FAIL full_ack: got %b/%h expected 0010/11", p_ack, p_rdata); end
        tick(); c_ack = 1'b0;
        for (int c = 0; c < 6 && !got1; c++) begin
            #1;
            if (p_accept[1]) got1 = 1;
            tick();
        end
        p_rd = '0;
        checks++; if (!got1) begin errors++; $display("FAIL full_release: got 0 expected 1 accept"); end
        for (int k = 0; k < 4; k++) begin
            c_ack = 1'b1; #1;
            if (p_ack !== 4'b0010) bad2++;
            tick(); c_ack = 1'b0;
        end
        checks++; if (bad2 !== 0 || err_orphan !== 1'b0) begin errors++; $display("FAIL full_drain: got %0d bad acks orphan=%b expected 0/0", bad2, err_orphan); end
    endtask

    task automatic test_push_pop();
        do_reset();
        issue(1, 1'b1, 4'h0, 32'h10, 32'h0, cyc, crd, cwr, caddr, cwd);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL pp_issue: got %0d expected 1", cyc); end
        p_rd[3] = 1'b1; p_addr[127:96] = 32'h30;
        tick();
        c_ack = 1'b1; c_rdata = 32'hA1; #1;
        checks++; if (p_accept !== 4'b1000 || c_rd !== 1'b1) begin errors++; $display("FAIL pp_accept: got %b rd=%b expected 1000/1", p_accept, c_rd); end
        checks++; if (p_ack !== 4'b0010 || p_rdata !== 32'hA1) begin errors++; $display("FAIL pp_ack1: got %b/%h expected 0010/a1", p_ack, p_rdata); end
        tick(); c_ack = 1'b0; p_rd = '0;
        tick();
        c_ack = 1'b1; c_rdata = 32'hA3; #1;
        checks++; if (p_ack !== 4'b1000 || p_rdata !== 32'hA3) begin errors++; $display("FAIL pp_ack3: got %b/%h expected 1000/a3", p_ack, p_rdata); end
        tick(); #1;
        checks++; if (p_ack !== 4'b0) begin errors++; $display("FAIL pp_count: got %b expected 0000", p_ack); end
        tick(); c_ack = 1'b0; #1;
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL pp_orphan: got %b expected 1", err_orphan); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(1, 1'b1, 4'h0, 32'h50, 32'h0, cyc, crd, cwr, caddr, cwd);
        issue(2, 1'b1, 4'h0, 32'h60, 32'h0, cyc, crd, cwr, caddr, cwd);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL mid_issue: got %0d expected 1", cyc); end
        rst_n = 1'b0; #1;
        checks++; if (err_orphan !== 1'b0 || p_ack !== 4'b0) begin errors++; $display("FAIL mid_rst: got orphan=%b ack=%b expected 0/0000", err_orphan, p_ack); end
        tick(); rst_n = 1'b1; tick();
        c_ack = 1'b1; c_rdata = 32'h55; #1;
        checks++; if (p_ack !== 4'b0) begin errors++; $display("FAIL mid_stale_ack: got %b expected 0000", p_ack); end
        tick(); c_ack = 1'b0; tick(); tick();
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL mid_orphan: got %b expected 1", err_orphan); end
`ifdef SDRAM_ARB_STATS_EN
        checks++; if (lat_max !== '0) begin errors++; $display("FAIL mid_lat: got %h expected 0", lat_max); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fixed_priority();
        test_round_robin();
        test_violation();
        test_fifo_full();
        test_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sdram_arb_multi.md
Name: sdram_arb_multi

Overview:
- N-port successor to the dual-port SDRAM arbiter.
- Multiplexes NUM_PORTS client requests (rd / byte-enabled wr / addr / write_data) onto the single sdram_core_32bit request channel.
- Mixed arbitration: hybrid fixed-priority plus round-robin.
- Tracks outstanding reads in an in-order tag FIFO so that each core read ack is routed back to the issuing port.

Parameters:
- NUM_PORTS, 4, number of client ports (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MASK_W, DATA_W/8, byte-enable width of wr.
- PRIO_PORTS, 1, ports 0..PRIO_PORTS-1 are fixed-priority (lower index wins). Remaining ports are round-robin. Range 0..NUM_PORTS.
- RD_DEPTH, 4, max outstanding reads (tag FIFO depth, power of 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- p_rd  in  NUM_PORTS  per-port read request
- p_wr  in  NUM_PORTS*MASK_W  per-port write byte enables (slice i = port i)
- p_addr  in  NUM_PORTS*ADDR_W  per-port address
- p_wdata  in  NUM_PORTS*DATA_W  per-port write data
- p_accept  out  NUM_PORTS  request taken
- p_ack  out  NUM_PORTS  read data valid for port
- p_rdata  out  DATA_W  read data, broadcast to all ports
- c_rd  out  1  core read request
- c_wr  out  MASK_W  core write byte enables
- c_addr  out  ADDR_W  core address
- c_wdata  out  DATA_W  core write data
- c_accept  in  1  core took request
- c_ack  in  1  core read data valid (in issue order)
- c_rdata  in  DATA_W  core read data
- err_orphan  out  1  sticky: c_ack seen with tag FIFO empty

Behaviour:
- Request valid for port i: req_i = p_rd[i] | (|p_wr slice i).
- Clients hold the request until p_accept[i]. If rd and wr are both set, the request is a write and rd is ignored.
- State machine, two states:
  - IDLE: on any eligible request, register grant index g; go to BUSY. 1-cycle arbitration latency.
  - BUSY: c_rd/c_wr/c_addr/c_wdata are driven combinationally from port g. On c_accept: p_accept[g]=1 that cycle, go to IDLE. No new grant is issued in that cycle (min 2 cycles per request).
- Eligibility: a read request is ineligible while the tag FIFO is full. Writes are always eligible.
- Selection order:
  - Lowest-index eligible fixed-priority port first.
  - Otherwise, round-robin among ports PRIO_PORTS..NUM_PORTS-1, searching from rr_ptr+1 with wrap.
  - rr_ptr updates only when an RR port is accepted.
- A granted request is never revoked. If the client drops its request before accept (protocol violation), core outputs go inactive (c_rd=0, c_wr=0) and the state machine returns to IDLE.
- Tag FIFO push: on c_accept of a read, the port index is pushed.
- Tag FIFO pop: on c_ack, p_ack[head]=1 in the same cycle (combinational), p_rdata=c_rdata, then head is popped.
- Simultaneous push and pop: both take effect and the count is unchanged.
- c_ack with FIFO empty: no p_ack is asserted and err_orphan is set (cleared only by reset).
- Reset values: state IDLE, g=0, rr_ptr=NUM_PORTS-1, FIFO empty, err_orphan=0, all p_accept/p_ack/c_rd/c_wr = 0. c_addr/c_wdata/p_rdata are don't-care but driven 0 while idle.
- Reset mid-operation: in-flight grant and tags are discarded. Subsequent stale c_ack sets err_orphan.

Optional Feature:
- Macro: SDRAM_ARB_STATS_EN.
- When defined:
  - Adds output lat_max (NUM_PORTS*16). Per port, a saturating 16-bit counter of the worst cycles from req_i rising to p_accept[i], plus, for reads, to p_ack[i].
  - Adds input stats_clr (1), which zeroes all counters synchronously.
  - Counters reset to 0.
- When undefined: these ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Single write, then read: port 2 wr=4'hF, addr=32'h0000_0100, wdata=32'hDEAD_BEEF; then rd same addr -> exactly one p_accept[2] per request, p_ack[2] with p_rdata=32'hDEAD_BEEF, no other p_ack.
- Fixed priority preemption: PRIO_PORTS=1, ports 0..3 all requesting continuously -> port 0 is granted every arbitration. Once port 0 drops, ports 1,2,3,1,2,3 are granted in rotation.
- Round-robin fairness: ports 1..3 issue 400 random write/read pairs each -> 0 data errors; per-port accept counts differ by <=1 at every checkpoint.
- Tag FIFO full: RD_DEPTH=4, core withholds c_ack; 5 reads queued -> 4 accepted, 5th stalls with no c_rd. Pending writes on other ports are still accepted. First c_ack releases the 5th read.
- Simultaneous push/pop: c_ack for port 1 in the same cycle as c_accept of a read from port 3 -> p_ack[1]=1, FIFO count unchanged, later ack routes to port 3.
- Reset mid-operation: assert rst_n=0 with 2 reads outstanding, release, core delivers 1 stale c_ack -> no p_ack, err_orphan=1. With SDRAM_ARB_STATS_EN, all lat_max=0 after reset.
